reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/mips_pkg.sv | 14 +
 rtl/reg_dump.sv | 117 +++++++++++
 tb/tb_reg_dump.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core debug blocks.
// Holds the register-dump FSM state encoding and the hardwired-zero register index.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } dump_state_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/reg_dump.sv
// Streams a contiguous, wrapping range of register-file entries out over a
// valid/ready port, reading through the register file's debug read port.
module reg_dump
    import mips_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] first_reg,
    input  logic [AW-1:0] last_reg,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    dump_state_t   state;
    dump_state_t   state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] last_idx;
    logic          at_last;

    assign at_last = (idx == last_idx);
    assign ra      = idx;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort outranks every other condition outside IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start && !abort) state_nxt = LOAD;
            LOAD: state_nxt = abort ? IDLE : SEND;
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    state_nxt = at_last ? FIN : LOAD;
                end
            end
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status decodes of the state register
    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: ;
            LOAD: busy = 1'b1;
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Index, range latch and captured output word
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            last_idx <= '0;
            out_data <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        idx      <= first_reg;
                        last_idx <= last_reg;
                    end
                end
                LOAD: begin
                    if (!abort) begin
                        // Register 0 is hardwired to zero whatever the port returns
                        out_data <= (idx == AW'(REG_ZERO)) ? '0 : rd;
                        out_addr <= idx;
                        out_last <= at_last;
                    end
                end
                SEND: begin
                    if (!abort && out_ready && !at_last) begin
                        idx <= AW'(idx + AW'(1));
                    end
                end
                FIN: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump with a behavioural register file on the debug port.
module tb_reg_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int          total = 0;
    int          fails = 0;
    logic [4:0]  aq [$];
    logic [31:0] dq [$];
    logic        lq [$];

    assign rd = regs[ra];

    reg_dump #(.DW(32), .AW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .ra        (ra),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a dump with out_ready held high and record every word until done
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l);
        bit got_done;
        aq.delete();
        dq.delete();
        lq.delete();
        got_done  = 1'b0;
        out_ready = 1'b1;
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 200 && !got_done; k++) begin
            tick();
            if (out_valid) begin
                aq.push_back(out_addr);
                dq.push_back(out_data);
                lq.push_back(out_last);
            end
            if (done) got_done = 1'b1;
        end
        chk("dump_done_within_bound", 32'(got_done), 32'd1);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        first_reg = '0; last_reg = '0; out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_data",  out_data,       32'd0);
        chk("rst_addr",  32'(out_addr),  32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_ra",    32'(ra),        32'd0);
        reset = 1'b0;
        tick();

        // Two-word dump, cycle by cycle
        regs[1] = 32'h0000FFFF;
        regs[2] = 32'hFFFF0000;
        first_reg = 5'd1; last_reg = 5'd2; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_load_busy",  32'(busy),      32'd1);
        chk("t2_load_valid", 32'(out_valid), 32'd0);
        chk("t2_load_ra",    32'(ra),        32'd1);
        tick();
        chk("t2_w0_valid", 32'(out_valid), 32'd1);
        chk("t2_w0_data",  out_data,       32'h0000FFFF);
        chk("t2_w0_addr",  32'(out_addr),  32'd1);
        chk("t2_w0_last",  32'(out_last),  32'd0);
        tick();
        chk("t2_gap_valid", 32'(out_valid), 32'd0);
        chk("t2_gap_ra",    32'(ra),        32'd2);
        tick();
        chk("t2_w1_valid", 32'(out_valid), 32'd1);
        chk("t2_w1_data",  out_data,       32'hFFFF0000);
        chk("t2_w1_addr",  32'(out_addr),  32'd2);
        chk("t2_w1_last",  32'(out_last),  32'd1);
        tick();
        chk("t2_fin_done",  32'(done),      32'd1);
        chk("t2_fin_valid", 32'(out_valid), 32'd0);
        chk("t2_fin_busy",  32'(busy),      32'd1);
        tick();
        chk("t2_idle_done", 32'(done), 32'd0);
        chk("t2_idle_busy", 32'(busy), 32'd0);

        // Wrap through r31 to r0, which must read as zero
        regs[30] = 32'h01010101;
        regs[31] = 32'h0F0F0F0F;
        regs[0]  = 32'hDEADBEEF;
        run_dump(5'd30, 5'd0);
        chk("t3_count", 32'(aq.size()), 32'd3);
        if (aq.size() == 3) begin
            chk("t3_a0", 32'(aq[0]), 32'd30);
            chk("t3_d0", dq[0],      32'h01010101);
            chk("t3_a1", 32'(aq[1]), 32'd31);
            chk("t3_d1", dq[1],      32'h0F0F0F0F);
            chk("t3_a2", 32'(aq[2]), 32'd0);
            chk("t3_d2", dq[2],      32'h00000000);
            chk("t3_l2", 32'(lq[2]), 32'd1);
        end

        // Full 32-word wrap, first = last + 1
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5000000 | 32'(i);
        run_dump(5'd5, 5'd4);
        chk("t4_count", 32'(aq.size()), 32'd32);
        for (int i = 0; i < 32 && i < aq.size(); i++) begin
            logic [4:0] ea;
            ea = 5'((i + 5) % 32);
            chk($sformatf("t4_addr%0d", i), 32'(aq[i]), 32'(ea));
            chk($sformatf("t4_data%0d", i), dq[i], (ea == 5'd0) ? 32'h0 : (32'hA5000000 | 32'(ea)));
            chk($sformatf("t4_last%0d", i), 32'(lq[i]), (i == 31) ? 32'd1 : 32'd0);
        end

        // Back-pressure: word held stable while out_ready is low
        regs[3] = 32'h33333333;
        first_reg = 5'd3; last_reg = 5'd3; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        regs[3] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("t5_data%0d", i),  out_data,       32'h33333333);
            chk($sformatf("t5_addr%0d", i),  32'(out_addr),  32'd3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t5_fin_done",  32'(done),      32'd1);
        chk("t5_fin_valid", 32'(out_valid), 32'd0);
        tick();

        // Start while busy is ignored; abort in the second SEND
        regs[8] = 32'h00000088;
        regs[9] = 32'h00000099;
        first_reg = 5'd8; last_reg = 5'd11; out_ready = 1'b1; start = 1'b1;
        tick();
        first_reg = 5'd20; last_reg = 5'd20;
        tick();
        chk("t6_w0_addr", 32'(out_addr), 32'd8);
        chk("t6_w0_data", out_data,      32'h00000088);
        tick();
        chk("t6_ra_after_busy_start", 32'(ra), 32'd9);
        start = 1'b0;
        tick();
        chk("t6_w1_valid", 32'(out_valid), 32'd1);
        chk("t6_w1_addr",  32'(out_addr),  32'd9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_busy",  32'(busy),      32'd0);
        chk("t6_abort_valid", 32'(out_valid), 32'd0);
        chk("t6_abort_done",  32'(done),      32'd0);
        tick();
        chk("t6_post_done", 32'(done), 32'd0);
        chk("t6_post_busy", 32'(busy), 32'd0);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t7_busy", 32'(busy), 32'd0);

        // Reset during LOAD, then a fresh dump
        first_reg = 5'd2; last_reg = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t8_in_load_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t8_rst_busy",  32'(busy),      32'd0);
        chk("t8_rst_valid", 32'(out_valid), 32'd0);
        chk("t8_rst_data",  out_data,       32'd0);
        chk("t8_rst_ra",    32'(ra),        32'd0);
        chk("t8_rst_done",  32'(done),      32'd0);
        tick();
        chk("t8_idle_busy", 32'(busy), 32'd0);
        regs[1] = 32'h0000FFFF;
        regs[2] = 32'hFFFF0000;
        run_dump(5'd1, 5'd2);
        chk("t8_count", 32'(aq.size()), 32'd2);
        if (aq.size() == 2) begin
            chk("t8_d0", dq[0],      32'h0000FFFF);
            chk("t8_d1", dq[1],      32'hFFFF0000);
            chk("t8_l1", 32'(lq[1]), 32'd1);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
